alu_secuencial: RTL and testbench

Registered, handshaked successor to the combinational ALU, parametrised in data width and opcode width. It adds status flags, an invalid-opcode indication, and an optional iterative signed multiply (MUL). It sits between the instruction-decode/operand stage and the write-back/result register. Valid/ready on both sides allows back-pressure from the consumer.

---
 rtl/alu_pkg.sv | 80 ++++++++
 rtl/alu_mul_iterativo.sv | 54 +++++
 rtl/alu_secuencial.sv | 165 ++++++++++++++++
 tb/tb_alu_secuencial.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcodes, FSM states and the
// single-cycle result/flag function used by the top level.
package alu_pkg;

   // Width the datapath function works in; operands are sign-extended into it.
   localparam int MAXW   = 64;
   localparam int COD_OP = 6;

   localparam logic [COD_OP-1:0] OP_ADD = 6'b100000;
   localparam logic [COD_OP-1:0] OP_SUB = 6'b100010;
   localparam logic [COD_OP-1:0] OP_AND = 6'b100100;
   localparam logic [COD_OP-1:0] OP_OR  = 6'b100101;
   localparam logic [COD_OP-1:0] OP_XOR = 6'b100110;
   localparam logic [COD_OP-1:0] OP_NOR = 6'b100111;
   localparam logic [COD_OP-1:0] OP_SRL = 6'b000010;
   localparam logic [COD_OP-1:0] OP_SRA = 6'b000011;
   localparam logic [COD_OP-1:0] OP_MUL = 6'b011000;

   typedef enum logic [3:0] {
      K_ADD, K_SUB, K_AND, K_OR, K_XOR, K_NOR, K_SRL, K_SRA, K_MUL, K_INV
   } alu_op_e;

   typedef enum logic {
      ST_IDLE    = 1'b0,
      ST_MUL_RUN = 1'b1
   } state_e;

   typedef struct packed {
      logic [MAXW-1:0] res;
      logic            zero;
      logic            negativo;
      logic            carry;
      logic            overflow;
      logic            op_invalida;
   } alu_flags_t;

   // msb is the index of the operand sign bit (operand width - 1).
   function automatic alu_flags_t alu_calc(input alu_op_e         op,
                                           input logic [MAXW-1:0] a,
                                           input logic [MAXW-1:0] b,
                                           input logic [5:0]      msb);
      alu_flags_t      f;
      logic [MAXW-1:0] mask;
      logic [MAXW-1:0] au;
      logic [MAXW-1:0] bu;
      logic [MAXW-1:0] sum;
      mask = ~(({MAXW{1'b1}} << msb) << 1);
      au   = a & mask;
      bu   = b & mask;
      sum  = '0;
      f    = '0;
      case (op)
         K_ADD: begin
            sum        = au + bu;
            f.res      = sum;
            f.carry    = sum[msb + 6'd1];
            f.overflow = (a[msb] == b[msb]) && (sum[msb] != a[msb]);
         end
         K_SUB: begin
            // Carry out of A + ~B + 1 is the "no borrow" indication.
            sum        = au + (~bu & mask) + MAXW'(1);
            f.res      = sum;
            f.carry    = sum[msb + 6'd1];
            f.overflow = (a[msb] != b[msb]) && (sum[msb] != a[msb]);
         end
         K_AND: f.res = a & b;
         K_OR:  f.res = a | b;
         K_XOR: f.res = a ^ b;
         K_NOR: f.res = ~(a | b);
         K_SRL: f.res = au >> bu;
         K_SRA: f.res = $signed(a) >>> bu;
         default: f.op_invalida = 1'b1;
      endcase
      f.res      = f.res & mask;
      f.zero     = (f.res == '0) && !f.op_invalida;
      f.negativo = f.res[msb];
      return f;
   endfunction

endpackage

// File: rtl/alu_mul_iterativo.sv
// Unsigned shift-add multiplier: one multiplier bit per clock, NBITS clocks
// after start. done flags the final step; product is the value being loaded.
module alu_mul_iterativo #(
   parameter int NBITS = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [NBITS-1:0]   multiplicand,
   input  logic [NBITS-1:0]   multiplier,
   output logic               done,
   output logic [2*NBITS-1:0] product
);

   localparam int CW = $clog2(NBITS + 1);

   logic [2*NBITS-1:0] acc_reg;
   logic [2*NBITS-1:0] acc_next;
   logic [NBITS-1:0]   mcand_reg;
   logic [CW-1:0]      count_reg;
   logic               busy_reg;
   logic [NBITS:0]     partial;

   // Upper half accumulates, lower half shifts the multiplier out LSB first.
   always_comb begin
      partial  = {1'b0, acc_reg[2*NBITS-1:NBITS]}
               + (acc_reg[0] ? {1'b0, mcand_reg} : '0);
      acc_next = {partial, acc_reg[NBITS-1:1]};
   end

   assign done    = busy_reg && (count_reg == CW'(1));
   assign product = acc_next;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_reg   <= '0;
         mcand_reg <= '0;
         count_reg <= '0;
         busy_reg  <= 1'b0;
      end else if (start) begin
         acc_reg   <= {{NBITS{1'b0}}, multiplier};
         mcand_reg <= multiplicand;
         count_reg <= CW'(NBITS);
         busy_reg  <= 1'b1;
      end else if (busy_reg) begin
         acc_reg   <= acc_next;
         count_reg <= count_reg - CW'(1);
         if (count_reg == CW'(1)) begin
            busy_reg <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/alu_secuencial.sv
// Registered ALU with valid/ready on both sides, status flags, invalid-opcode
// reporting and an optional iterative signed multiply.
module alu_secuencial
   import alu_pkg::*;
#(
   parameter int NBITS  = 8,
   parameter int COD_OP = 6,
   parameter bit MUL_EN = 1'b1
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_valid,
   output logic              o_ready,
   input  logic [NBITS-1:0]  i_operando_A,
   input  logic [NBITS-1:0]  i_operando_B,
   input  logic [COD_OP-1:0] i_cod_operacion,
   output logic              o_valid,
   input  logic              i_ready,
   output logic [NBITS-1:0]  o_resultado,
   output logic              o_zero,
   output logic              o_negativo,
   output logic              o_carry,
   output logic              o_overflow,
   output logic              o_op_invalida
);

   localparam logic [5:0] MSB = 6'(NBITS - 1);

   state_e             state_reg;
   state_e             state_next;
   alu_op_e            op_sel;
   alu_flags_t         calc;
   logic [MAXW-1:0]    a_ext;
   logic [MAXW-1:0]    b_ext;
   logic               accept;
   logic               mul_start;
   logic               mul_done;
   logic [2*NBITS-1:0] mul_product;
   logic [2*NBITS-1:0] prod_signed;
   logic               mul_ovf;
   logic [NBITS-1:0]   mag_a;
   logic [NBITS-1:0]   mag_b;
   logic               prod_neg_reg;
   logic               valid_reg;
   logic [NBITS-1:0]   res_reg;
   logic               zero_reg;
   logic               neg_reg;
   logic               carry_reg;
   logic               ovf_reg;
   logic               inv_reg;
   logic               unused_calc_hi;

   always_comb begin
      op_sel = K_INV;
      if      (i_cod_operacion == COD_OP'(OP_ADD))           op_sel = K_ADD;
      else if (i_cod_operacion == COD_OP'(OP_SUB))           op_sel = K_SUB;
      else if (i_cod_operacion == COD_OP'(OP_AND))           op_sel = K_AND;
      else if (i_cod_operacion == COD_OP'(OP_OR))            op_sel = K_OR;
      else if (i_cod_operacion == COD_OP'(OP_XOR))           op_sel = K_XOR;
      else if (i_cod_operacion == COD_OP'(OP_NOR))           op_sel = K_NOR;
      else if (i_cod_operacion == COD_OP'(OP_SRL))           op_sel = K_SRL;
      else if (i_cod_operacion == COD_OP'(OP_SRA))           op_sel = K_SRA;
      else if (MUL_EN && i_cod_operacion == COD_OP'(OP_MUL)) op_sel = K_MUL;
   end

   assign a_ext          = MAXW'($signed(i_operando_A));
   assign b_ext          = MAXW'($signed(i_operando_B));
   assign calc           = alu_calc(op_sel, a_ext, b_ext, MSB);
   assign unused_calc_hi = ^calc.res[MAXW-1:NBITS];

   assign accept    = i_valid && o_ready;
   assign mul_start = accept && (op_sel == K_MUL);

   // The core multiplies magnitudes; the sign is reapplied when it finishes.
   assign mag_a = i_operando_A[NBITS-1] ? -i_operando_A : i_operando_A;
   assign mag_b = i_operando_B[NBITS-1] ? -i_operando_B : i_operando_B;

   generate
      if (MUL_EN) begin : g_mul
         alu_mul_iterativo #(
            .NBITS(NBITS)
         ) u_mul (
            .clk          (i_clk),
            .rst_n        (i_rst_n),
            .start        (mul_start),
            .multiplicand (mag_a),
            .multiplier   (mag_b),
            .done         (mul_done),
            .product      (mul_product)
         );
      end else begin : g_no_mul
         assign mul_done    = 1'b0;
         assign mul_product = '0;
      end
   endgenerate

   assign prod_signed = prod_neg_reg ? -mul_product : mul_product;
   // Fits in signed NBITS only if the top NBITS+1 bits are a pure sign run.
   assign mul_ovf = (prod_signed[2*NBITS-1:NBITS-1] != '0)
                 && (prod_signed[2*NBITS-1:NBITS-1] != '1);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_reg <= ST_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE:    if (mul_start) state_next = ST_MUL_RUN;
         ST_MUL_RUN: if (mul_done)  state_next = ST_IDLE;
         default:    state_next = ST_IDLE;
      endcase
   end

   always_comb begin
      o_ready = (state_reg == ST_IDLE) && (!valid_reg || i_ready);
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         valid_reg    <= 1'b0;
         res_reg      <= '0;
         zero_reg     <= 1'b0;
         neg_reg      <= 1'b0;
         carry_reg    <= 1'b0;
         ovf_reg      <= 1'b0;
         inv_reg      <= 1'b0;
         prod_neg_reg <= 1'b0;
      end else if (accept && op_sel != K_MUL) begin
         valid_reg <= 1'b1;
         res_reg   <= calc.res[NBITS-1:0];
         zero_reg  <= calc.zero;
         neg_reg   <= calc.negativo;
         carry_reg <= calc.carry;
         ovf_reg   <= calc.overflow;
         inv_reg   <= calc.op_invalida;
      end else if (accept) begin
         valid_reg    <= 1'b0;
         prod_neg_reg <= i_operando_A[NBITS-1] ^ i_operando_B[NBITS-1];
      end else if (state_reg == ST_MUL_RUN && mul_done) begin
         valid_reg <= 1'b1;
         res_reg   <= prod_signed[NBITS-1:0];
         zero_reg  <= (prod_signed[NBITS-1:0] == '0);
         neg_reg   <= prod_signed[NBITS-1];
         carry_reg <= 1'b0;
         ovf_reg   <= mul_ovf;
         inv_reg   <= 1'b0;
      end else if (valid_reg && i_ready) begin
         valid_reg <= 1'b0;
      end
   end

   assign o_valid       = valid_reg;
   assign o_resultado   = res_reg;
   assign o_zero        = zero_reg;
   assign o_negativo    = neg_reg;
   assign o_carry       = carry_reg;
   assign o_overflow    = ovf_reg;
   assign o_op_invalida = inv_reg;

endmodule

// File: tb/tb_alu_secuencial.sv
// Bench for alu_secuencial: directed vector table, handshake/reset sequences
// and random operations against an integer-arithmetic reference model.
module tb_alu_secuencial;

   localparam logic [5:0] C_ADD = 6'b100000;
   localparam logic [5:0] C_SUB = 6'b100010;
   localparam logic [5:0] C_AND = 6'b100100;
   localparam logic [5:0] C_OR  = 6'b100101;
   localparam logic [5:0] C_XOR = 6'b100110;
   localparam logic [5:0] C_NOR = 6'b100111;
   localparam logic [5:0] C_SRL = 6'b000010;
   localparam logic [5:0] C_SRA = 6'b000011;
   localparam logic [5:0] C_MUL = 6'b011000;

   logic       i_clk;
   logic       i_rst_n;
   logic       i_valid;
   logic       i_ready;
   logic [7:0] i_operando_A;
   logic [7:0] i_operando_B;
   logic [5:0] i_cod_operacion;

   logic       o_ready, o_valid, o_zero, o_negativo, o_carry, o_overflow, o_op_invalida;
   logic [7:0] o_resultado;
   logic       n_ready, n_valid, n_zero, n_neg, n_carry, n_ovf, n_inv;
   logic [7:0] n_res;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [5:0]  code;
      logic [7:0]  a;
      logic [7:0]  b;
      logic [12:0] exp;   // {result, zero, negativo, carry, overflow, op_invalida}
      int          lat;
   } vec_t;

   vec_t        tbl [18];
   logic [5:0]  codes [9] = '{C_ADD, C_SUB, C_AND, C_OR, C_XOR, C_NOR, C_SRL, C_SRA, C_MUL};
   logic [12:0] got;
   int          lat;
   logic [5:0]  rcode;
   logic [7:0]  ra, rb;

   alu_secuencial #(.NBITS(8), .COD_OP(6), .MUL_EN(1'b1)) dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
      .i_operando_A(i_operando_A), .i_operando_B(i_operando_B),
      .i_cod_operacion(i_cod_operacion), .o_valid(o_valid), .i_ready(i_ready),
      .o_resultado(o_resultado), .o_zero(o_zero), .o_negativo(o_negativo),
      .o_carry(o_carry), .o_overflow(o_overflow), .o_op_invalida(o_op_invalida)
   );

   alu_secuencial #(.NBITS(8), .COD_OP(6), .MUL_EN(1'b0)) dut_nomul (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(n_ready),
      .i_operando_A(i_operando_A), .i_operando_B(i_operando_B),
      .i_cod_operacion(i_cod_operacion), .o_valid(n_valid), .i_ready(i_ready),
      .o_resultado(n_res), .o_zero(n_zero), .o_negativo(n_neg),
      .o_carry(n_carry), .o_overflow(n_ovf), .o_op_invalida(n_inv)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   initial begin
      #1000000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   function automatic logic [12:0] model(input logic [5:0] code, input logic [7:0] a,
                                         input logic [7:0] b);
      int sa, sb, ua, ub, r, wide;
      logic c, v, inv, z;
      logic [7:0] res;
      sa = $signed(a);
      sb = $signed(b);
      ua = a;
      ub = b;
      c = 1'b0; v = 1'b0; inv = 1'b0; r = 0;
      case (code)
         C_ADD: begin
            r = ua + ub;
            c = (r > 255);
            v = (sa + sb > 127) || (sa + sb < -128);
         end
         C_SUB: begin
            r = ua - ub;
            c = (ua >= ub);
            v = (sa - sb > 127) || (sa - sb < -128);
         end
         C_AND: r = ua & ub;
         C_OR:  r = ua | ub;
         C_XOR: r = ua ^ ub;
         C_NOR: r = ~(ua | ub);
         C_SRL: r = (ub >= 8) ? 0 : (ua >> ub);
         C_SRA: r = (ub >= 8) ? ((sa < 0) ? -1 : 0) : (sa >>> ub);
         C_MUL: begin
            wide = sa * sb;
            r = wide;
            v = (wide > 127) || (wide < -128);
         end
         default: inv = 1'b1;
      endcase
      res = r[7:0];
      z = (res == 8'h00) && !inv;
      return {res, z, res[7], c, v, inv};
   endfunction

   task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", name, actual, expected);
      end
   endtask

   // Issue one op with i_ready=1; lat = edges from accept until o_valid.
   task automatic run_op(input logic [5:0] code, input logic [7:0] a, input logic [7:0] b,
                         output logic [12:0] res, output int latency);
      int   w;
      logic leak;
      @(negedge i_clk);
      i_cod_operacion = code;
      i_operando_A    = a;
      i_operando_B    = b;
      i_valid         = 1'b1;
      i_ready         = 1'b1;
      w = 0;
      while (!o_ready && w < 40) begin
         @(negedge i_clk);
         w++;
      end
      if (!o_ready) check("ready_timeout", 32'(o_ready), 32'd1);
      @(posedge i_clk);
      #1;
      i_valid = 1'b0;
      if (code == C_MUL)
         check("mul_en0_invalid", {n_valid, n_res, n_inv, n_zero, n_neg, n_carry, n_ovf},
               {1'b1, 8'h00, 1'b1, 4'b0000});
      latency = 0;
      leak = 1'b0;
      while (!o_valid && latency < 40) begin
         if (o_ready) leak = 1'b1;
         @(posedge i_clk);
         #1;
         latency++;
      end
      if (code == C_MUL) check("mul_ready_low", 32'(leak), 32'd0);
      res = {o_resultado, o_zero, o_negativo, o_carry, o_overflow, o_op_invalida};
      $display("op=%b a=%h b=%h res=%h zncvi=%b lat=%0d", code, a, b, res[12:5], res[4:0], latency);
   endtask

   initial begin
      tbl[0]  = '{C_ADD, 8'h7F, 8'h01, {8'h80, 5'b01010}, 0};
      tbl[1]  = '{C_SUB, 8'h05, 8'h05, {8'h00, 5'b10100}, 0};
      tbl[2]  = '{C_SRA, 8'h80, 8'h03, {8'hF0, 5'b01000}, 0};
      tbl[3]  = '{C_SRA, 8'h80, 8'h09, {8'hFF, 5'b01000}, 0};
      tbl[4]  = '{C_SRL, 8'h80, 8'h09, {8'h00, 5'b10000}, 0};
      tbl[5]  = '{C_NOR, 8'h0F, 8'hF0, {8'h00, 5'b10000}, 0};
      tbl[6]  = '{C_MUL, 8'hFD, 8'h05, {8'hF1, 5'b01000}, 8};
      tbl[7]  = '{C_MUL, 8'h10, 8'h10, {8'h00, 5'b10010}, 8};
      tbl[8]  = '{6'b111111, 8'h55, 8'hAA, {8'h00, 5'b00001}, 0};
      tbl[9]  = '{C_AND, 8'hF0, 8'h3C, {8'h30, 5'b00000}, 0};
      tbl[10] = '{C_SRL, 8'h80, 8'h00, {8'h80, 5'b01000}, 0};
      tbl[11] = '{C_SUB, 8'h03, 8'h05, {8'hFE, 5'b01000}, 0};
      tbl[12] = '{C_ADD, 8'hFF, 8'h01, {8'h00, 5'b10100}, 0};
      tbl[13] = '{C_MUL, 8'h80, 8'h80, {8'h00, 5'b10010}, 8};
      tbl[14] = '{C_MUL, 8'h80, 8'h01, {8'h80, 5'b01000}, 8};
      tbl[15] = '{C_SUB, 8'h80, 8'h01, {8'h7F, 5'b00110}, 0};
      tbl[16] = '{C_XOR, 8'hA5, 8'hFF, {8'h5A, 5'b00000}, 0};
      tbl[17] = '{C_OR,  8'h00, 8'h00, {8'h00, 5'b10000}, 0};

      i_rst_n = 1'b0;
      i_valid = 1'b0;
      i_ready = 1'b1;
      i_operando_A = '0;
      i_operando_B = '0;
      i_cod_operacion = '0;
      #12;
      check("reset_outputs", {o_valid, o_resultado, o_zero, o_negativo, o_carry, o_overflow, o_op_invalida}, '0);
      @(negedge i_clk);
      i_rst_n = 1'b1;
      check("ready_after_reset", 32'(o_ready), 32'd1);

      for (int i = 0; i < 18; i++) begin
         run_op(tbl[i].code, tbl[i].a, tbl[i].b, got, lat);
         check($sformatf("vec%0d_out", i), 32'(got), 32'(tbl[i].exp));
         check($sformatf("vec%0d_lat", i), lat, tbl[i].lat);
      end

      // Back-pressure: second op held off, first result stable, then both drain in order.
      @(negedge i_clk);
      i_valid = 1'b0;
      i_ready = 1'b1;
      @(posedge i_clk);
      #1;
      check("drain_valid", 32'(o_valid), 32'd0);
      @(negedge i_clk);
      i_ready = 1'b0;
      i_cod_operacion = C_ADD;
      i_operando_A = 8'h01;
      i_operando_B = 8'h02;
      i_valid = 1'b1;
      @(posedge i_clk);
      #1;
      check("bp_first", {o_valid, o_resultado}, {1'b1, 8'h03});
      @(negedge i_clk);
      i_operando_A = 8'h10;
      i_operando_B = 8'h20;
      for (int c = 0; c < 5; c++) begin
         check("bp_hold", {o_ready, o_valid, o_resultado}, {1'b0, 1'b1, 8'h03});
         @(negedge i_clk);
      end
      i_ready = 1'b1;
      @(posedge i_clk);
      #1;
      check("bp_second", {o_valid, o_resultado}, {1'b1, 8'h30});
      i_valid = 1'b0;
      @(posedge i_clk);
      #1;
      check("bp_valid_drop", 32'(o_valid), 32'd0);

      // Asynchronous reset four edges into a multiply.
      run_op(C_ADD, 8'h7F, 8'h01, got, lat);
      @(negedge i_clk);
      i_cod_operacion = C_MUL;
      i_operando_A = 8'h07;
      i_operando_B = 8'h06;
      i_valid = 1'b1;
      @(posedge i_clk);
      #1;
      i_valid = 1'b0;
      repeat (4) @(posedge i_clk);
      #2;
      i_rst_n = 1'b0;
      #1;
      check("async_reset", {o_valid, o_resultado, o_zero, o_negativo, o_carry, o_overflow, o_op_invalida}, '0);
      @(negedge i_clk);
      i_rst_n = 1'b1;
      check("ready_after_abort", 32'(o_ready), 32'd1);
      run_op(C_ADD, 8'h02, 8'h03, got, lat);
      check("post_reset_add", 32'(got), 32'({8'h05, 5'b00000}));
      check("post_reset_lat", lat, 0);

      for (int k = 0; k < 150; k++) begin
         if ($urandom_range(9, 0) == 0) rcode = 6'($urandom);
         else                           rcode = codes[$urandom_range(8, 0)];
         ra = 8'($urandom);
         rb = ($urandom_range(3, 0) == 0) ? 8'($urandom_range(12, 0)) : 8'($urandom);
         run_op(rcode, ra, rb, got, lat);
         check("rand_out", 32'(got), 32'(model(rcode, ra, rb)));
         check("rand_lat", lat, (rcode == C_MUL) ? 8 : 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
